// File: rtl/aurora_rst_seq_ctrl.sv
// Aurora 64B66B reset_pb / pma_init bring-up and recovery sequencer with channel_up timeout and retry.
// Optional macro ARS_LINK_DEBOUNCE_EN: tolerate P_DEBOUNCE low channel_up cycles in LINK_OK.
module aurora_rst_seq_ctrl #(
    parameter int unsigned P_PB_LEAD      = 16,
    parameter int unsigned P_PMA_HOLD     = 128,
    parameter int unsigned P_PB_LAG       = 64,
    parameter int unsigned P_LINK_TIMEOUT = 1000000,
    parameter int unsigned P_MAX_RETRY    = 8,
    parameter int unsigned P_AUTO_START   = 1,
    parameter int unsigned P_CNT_W        = 24,
    parameter int unsigned P_DEBOUNCE     = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_channel_up,
    output logic       o_reset_pb,
    output logic       o_pma_init,
    output logic       o_link_ready,
    output logic       o_fail,
    output logic [7:0] o_retry_cnt,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PB_LEAD  = 3'd1,
        S_PMA_HOLD = 3'd2,
        S_PB_LAG   = 3'd3,
        S_WAIT_UP  = 3'd4,
        S_LINK_OK  = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    // Each timed state ends on the cycle its counter reaches N-1; zero lengths act as one cycle.
    localparam logic [P_CNT_W-1:0] LEAD_LAST = P_CNT_W'((P_PB_LEAD      == 0) ? 0 : P_PB_LEAD      - 1);
    localparam logic [P_CNT_W-1:0] HOLD_LAST = P_CNT_W'((P_PMA_HOLD     == 0) ? 0 : P_PMA_HOLD     - 1);
    localparam logic [P_CNT_W-1:0] LAG_LAST  = P_CNT_W'((P_PB_LAG       == 0) ? 0 : P_PB_LAG       - 1);
    localparam logic [P_CNT_W-1:0] TMO_LAST  = P_CNT_W'((P_LINK_TIMEOUT == 0) ? 0 : P_LINK_TIMEOUT - 1);
`ifdef ARS_LINK_DEBOUNCE_EN
    localparam logic [P_CNT_W-1:0] DEB_LAST  = P_CNT_W'((P_DEBOUNCE     == 0) ? 0 : P_DEBOUNCE     - 1);
`endif

    if ((64'(P_LINK_TIMEOUT) >= (64'd1 << P_CNT_W)) || (64'(P_DEBOUNCE) > (64'd1 << P_CNT_W)))
    begin : g_param_check
        $error("aurora_rst_seq_ctrl: P_CNT_W too narrow for timeout/debounce length");
    end

    state_t             state, state_nxt;
    logic [P_CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]         retry_nxt;
    logic               reset_pb_nxt, pma_init_nxt, link_ready_nxt, fail_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        retry_nxt = o_retry_cnt;
        case (state)
            S_IDLE: begin
                if ((P_AUTO_START != 0) || i_start) begin
                    state_nxt = S_PB_LEAD;
                    retry_nxt = '0;
                end
            end
            S_PB_LEAD: begin
                if (cnt == LEAD_LAST) state_nxt = S_PMA_HOLD;
                else                  cnt_nxt   = cnt + 1'b1;
            end
            S_PMA_HOLD: begin
                if (cnt == HOLD_LAST) state_nxt = S_PB_LAG;
                else                  cnt_nxt   = cnt + 1'b1;
            end
            S_PB_LAG: begin
                if (cnt == LAG_LAST) state_nxt = S_WAIT_UP;
                else                 cnt_nxt   = cnt + 1'b1;
            end
            S_WAIT_UP: begin
                // channel_up takes priority over a timeout landing on the same cycle
                if (i_channel_up) begin
                    state_nxt = S_LINK_OK;
                end else if (cnt == TMO_LAST) begin
                    if (o_retry_cnt != 8'hFF) retry_nxt = o_retry_cnt + 8'd1;
                    if ((P_MAX_RETRY != 0) && (32'(retry_nxt) >= P_MAX_RETRY)) state_nxt = S_FAIL;
                    else                                                        state_nxt = S_PB_LEAD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_LINK_OK: begin
`ifdef ARS_LINK_DEBOUNCE_EN
                if (!i_channel_up) begin
                    if (cnt == DEB_LAST) state_nxt = S_PB_LEAD;
                    else                 cnt_nxt   = cnt + 1'b1;
                end
`else
                if (!i_channel_up) state_nxt = S_PB_LEAD;
`endif
            end
            S_FAIL: begin
                if (i_start) begin
                    state_nxt = S_PB_LEAD;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Pin levels are decoded from the next state so they register in step with it.
        reset_pb_nxt   = 1'b1;
        pma_init_nxt   = 1'b1;
        link_ready_nxt = 1'b0;
        fail_nxt       = 1'b0;
        case (state_nxt)
            S_PB_LEAD:  pma_init_nxt = 1'b0;
            S_PB_LAG:   pma_init_nxt = 1'b0;
            S_WAIT_UP: begin
                reset_pb_nxt = 1'b0;
                pma_init_nxt = 1'b0;
            end
            S_LINK_OK: begin
                reset_pb_nxt   = 1'b0;
                pma_init_nxt   = 1'b0;
                link_ready_nxt = 1'b1;
            end
            S_FAIL:     fail_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            o_reset_pb   <= 1'b1;
            o_pma_init   <= 1'b1;
            o_link_ready <= 1'b0;
            o_fail       <= 1'b0;
            o_retry_cnt  <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            o_reset_pb   <= reset_pb_nxt;
            o_pma_init   <= pma_init_nxt;
            o_link_ready <= link_ready_nxt;
            o_fail       <= fail_nxt;
            o_retry_cnt  <= retry_nxt;
        end
    end

    assign o_state = state;

endmodule
